feistel_round_engine: RTL and testbench

Block-cipher datapath sitting directly downstream of the round-key generator. Fetches `ROUNDS` 48-bit round keys once over the generator's start/ready handshake, caches them, then encrypts or decrypts 64-bit blocks through an iterative LFSR-mixed Feistel network, one round per clock. Blocks enter and leave through valid/ready handshakes; the cached keys are reused until reset or an explicit reload.

---
 rtl/feistel_round_engine.sv | 149 ++++++++++++++
 tb/tb_feistel_round_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feistel_round_engine.sv
// Iterative Feistel block engine: caches ROUNDS round keys from the key generator and runs one round per clock.
// Optional per-round LFSR mixing is built in when FEISTEL_LFSR_EN is defined.
module feistel_round_engine #(
    parameter int          ROUNDS    = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    input  logic        key_reload,
    output logic        kg_start,
    output logic        kg_mode,
    input  logic [47:0] kg_key,
    input  logic        kg_ready,
    output logic        busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and out_data is held stable while out_valid is high.
    localparam int            KW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [KW-1:0] LAST = KW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ROUND = 2'd2, OUT = 2'd3} state_t;
    state_t state, state_nxt;

    logic [47:0]   key_buf [ROUNDS];
    logic          cache_valid, reload_pend;
    logic [KW-1:0] kidx, ridx, jidx;
    logic [31:0]   l_q, r_q, lfsr_term, mix, f_val;
    logic [47:0]   t_val;
    logic          dec_q;
    logic [63:0]   out_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // A reload pulse seen in IDLE forces a fetch for the block arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (cache_valid && !key_reload) ? ROUND : FETCH;
            FETCH:   if (kg_ready && kidx == LAST) state_nxt = ROUND;
            ROUND:   if (ridx == LAST) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst && (state == IDLE);
        kg_start  = (state == FETCH);
        kg_mode   = 1'b0;
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    assign out_data = out_q;

    // Decryption walks the same cached tables backwards.
    assign jidx = dec_q ? (LAST - ridx) : ridx;

    always_comb begin
        t_val = {r_q, r_q[31:16]} ^ key_buf[jidx];
        mix   = t_val[47:16] ^ {t_val[15:0], t_val[15:0]};
        f_val = {mix[28:0], mix[31:29]} ^ lfsr_term;
    end

`ifdef FEISTEL_LFSR_EN
    logic [31:0] lfsr_buf [ROUNDS];
    logic [31:0] lfsr_cur;

    // One Galois step per captured key keeps lfsr_buf[k] aligned with key_buf[k].
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_cur <= LFSR_SEED;
            for (int i = 0; i < ROUNDS; i++) lfsr_buf[i] <= '0;
        end else if (state == FETCH) begin
            if (kg_ready) begin
                lfsr_buf[kidx] <= lfsr_cur;
                lfsr_cur       <= {1'b0, lfsr_cur[31:1]} ^ (lfsr_cur[0] ? 32'h8020_0003 : 32'h0);
            end
        end else begin
            lfsr_cur <= LFSR_SEED;
        end
    end

    assign lfsr_term = lfsr_buf[jidx];
`else
    // The seed only has meaning with the LFSR built in; here the term is zero.
    assign lfsr_term = LFSR_SEED & 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid <= 1'b0;
            reload_pend <= 1'b0;
            kidx        <= '0;
            ridx        <= '0;
            l_q         <= '0;
            r_q         <= '0;
            dec_q       <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < ROUNDS; i++) key_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_reload) cache_valid <= 1'b0;
                    if (in_valid) begin
                        l_q   <= in_data[63:32];
                        r_q   <= in_data[31:0];
                        dec_q <= in_decrypt;
                        kidx  <= '0;
                        ridx  <= '0;
                    end
                end
                FETCH: begin
                    if (kg_ready) begin
                        key_buf[kidx] <= kg_key;
                        kidx          <= kidx + KW'(1);
                        if (kidx == LAST) cache_valid <= 1'b1;
                    end
                end
                ROUND: begin
                    l_q  <= r_q;
                    r_q  <= l_q ^ f_val;
                    ridx <= ridx + KW'(1);
                    if (ridx == LAST) out_q <= {l_q ^ f_val, r_q};
                    if (key_reload) reload_pend <= 1'b1;
                end
                OUT: begin
                    if (key_reload) reload_pend <= 1'b1;
                    // A reload requested mid-block lands once the result is taken.
                    if (out_ready && (reload_pend || key_reload)) begin
                        cache_valid <= 1'b0;
                        reload_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_feistel_round_engine.sv
// Self-checking bench for feistel_round_engine: modelled key generator, directed steps with random data,
// scoreboard queue against a behavioural Feistel model.
module tb_feistel_round_engine;
    localparam int          R    = 8;
    localparam logic [31:0] SEED = 32'hACE1_1234;
    localparam int          P    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, in_decrypt, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic        key_reload, kg_start, kg_mode, kg_ready, busy;
    logic [47:0] kg_key;

    initial forever #(P / 2) clk = ~clk;

    feistel_round_engine #(.ROUNDS(R), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_reload(key_reload), .kg_start(kg_start), .kg_mode(kg_mode),
        .kg_key(kg_key), .kg_ready(kg_ready), .busy(busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [47:0] gen_keys    [R];
    logic [47:0] cached_keys [R];
    logic [63:0] exp_q[$];
    int          gen_idx;
    bit          gap_en = 1'b0;
    int          cap_cnt = 0, fetch_cnt = 0, viol_cnt = 0;
    bit          kg_start_d = 1'b0;
    time         t_cap, t_acc, t_out;
    logic        ks_after;

    // Key generator: serves keys 0..R-1 while kg_start is high, junk strobes otherwise.
    initial begin
        kg_ready = 1'b0;
        kg_key   = '0;
        gen_idx  = 0;
        forever begin
            @(negedge clk);
            if (kg_start && gen_idx < R && (!gap_en || $urandom_range(0, 3) != 0)) begin
                kg_ready = 1'b1;
                kg_key   = gen_keys[gen_idx];
                gen_idx++;
            end else if (kg_start) begin
                kg_ready = 1'b0;
            end else begin
                gen_idx  = 0;
                kg_ready = 1'($urandom_range(0, 1));
                kg_key   = 48'({$urandom(), $urandom()});
            end
        end
    end

    always @(posedge clk) begin
        if (rst && kg_start && kg_ready) begin
            cap_cnt++;
            t_cap = $time;
        end
        if (rst && kg_start && !kg_start_d) fetch_cnt++;
        if (kg_start && (!busy || out_valid)) viol_cnt++;
        kg_start_d = kg_start;
    end

    initial begin
        #(P * 50000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] blk, input logic dec);
        logic [31:0] l, r, tmp, m, f;
        logic [31:0] lf [R];
        logic [47:0] t;
        int          j;
        l = blk[63:32];
        r = blk[31:0];
        lf[0] = SEED;
        for (int i = 1; i < R; i++)
            lf[i] = (lf[i-1] >> 1) ^ (lf[i-1][0] ? 32'h8020_0003 : 32'h0);
        for (int i = 0; i < R; i++) begin
            j = dec ? (R - 1 - i) : i;
            t = {r, r[31:16]} ^ cached_keys[j];
            m = t[47:16] ^ {t[15:0], t[15:0]};
            f = (m << 3) | (m >> 29);
`ifdef FEISTEL_LFSR_EN
            f = f ^ lf[j];
`endif
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        return {r, l};
    endfunction

    task automatic new_keys();
        for (int i = 0; i < R; i++) gen_keys[i] = 48'({$urandom(), $urandom()});
    endtask

    task automatic pulse_reload();
        key_reload = 1'b1;
        @(negedge clk);
        key_reload = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [63:0] d, input logic dec);
        int n = 0;
        in_data    = d;
        in_decrypt = dec;
        in_valid   = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 200), 64'd0);
        t_acc = $time;
        @(negedge clk);
        in_valid = 1'b0;
        ks_after = kg_start;
    endtask

    task automatic recv(input int hold);
        int          n = 0;
        logic [63:0] held, e;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("output_timeout", 64'(n >= 500), 64'd0);
        t_out = $time;
        held  = out_data;
        e     = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("out_data", held, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = ~held;
            @(negedge clk);
            check("hold_data", out_data, held);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drained", 64'({out_valid, busy}), 64'd0);
    endtask

    initial begin
        logic [63:0] pt, ct, d;
        logic        dec;
        time         prev;
        int          c0, f0;

        in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0;
        out_ready = 1'b1; key_reload = 1'b0; rst = 1'b0;
        new_keys();

        // reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_kg", 64'({kg_start, kg_mode, busy}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // first block fetches the keys
        cached_keys = gen_keys;
        c0 = cap_cnt; f0 = fetch_cnt;
        pt = 64'h0123_4567_89AB_CDEF;
        send(pt, 1'b0);
        check("kg_start_after_miss", 64'(ks_after), 64'd1);
        ct = model(pt, 1'b0);
        exp_q.push_back(ct);
        recv(0);
        check("captures", 64'(cap_cnt - c0), 64'(R));
        check("fetches_first", 64'(fetch_cnt - f0), 64'd1);
        check("capture_to_out", 64'((t_out - t_cap) / P), 64'(R));

        // decrypt on cached keys, consumer stalls for 5 cycles
        f0 = fetch_cnt;
        out_ready = 1'b0;
        send(ct, 1'b1);
        check("no_kg_start_on_hit", 64'(ks_after), 64'd0);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        recv(5);
        check("hit_latency", 64'((t_out - t_acc) / P), 64'(R + 1));
        check("no_fetch_on_hit", 64'(fetch_cnt - f0), 64'd0);

        // random cached traffic at full rate
        gap_en = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            d   = {$urandom(), $urandom()};
            dec = 1'($urandom_range(0, 1));
            send(d, dec);
            if (i > 0) check("throughput", 64'((t_acc - prev) / P), 64'(R + 2));
            prev = t_acc;
            exp_q.push_back(model(d, dec));
            recv(0);
        end

        // reload in IDLE: next block fetches; a pulse during that fetch is ignored
        pulse_reload();
        new_keys();
        cached_keys = gen_keys;
        f0 = fetch_cnt;
        d = {$urandom(), $urandom()};
        send(d, 1'b0);
        check("kg_start_after_reload", 64'(ks_after), 64'd1);
        pulse_reload();
        exp_q.push_back(model(d, 1'b0));
        recv(0);
        d = {$urandom(), $urandom()};
        send(d, 1'b1);
        check("fetch_pulse_ignored", 64'(ks_after), 64'd0);
        exp_q.push_back(model(d, 1'b1));
        recv(0);
        check("one_fetch_per_reload", 64'(fetch_cnt - f0), 64'd1);

        // reload mid-block applies after that block finishes
        d = {$urandom(), $urandom()};
        send(d, 1'b0);
        pulse_reload();
        exp_q.push_back(model(d, 1'b0));
        new_keys();
        recv(0);
        cached_keys = gen_keys;
        d = {$urandom(), $urandom()};
        send(d, 1'b0);
        check("refetch_after_mid_reload", 64'(ks_after), 64'd1);
        exp_q.push_back(model(d, 1'b0));
        recv(0);

        // reset at round 4 discards the block and the cache
        send({$urandom(), $urandom()}, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midround_rst_out", 64'({out_valid, kg_start, busy, in_ready}), 64'd0);
        check("midround_rst_data", out_data, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        new_keys();
        cached_keys = gen_keys;
        send({$urandom(), $urandom()}, 1'b0);
        check("refetch_after_rst", 64'(ks_after), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midfetch_rst", 64'({kg_start, busy, out_valid}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        d = {$urandom(), $urandom()};
        send(d, 1'b1);
        check("refetch_after_fetch_rst", 64'(ks_after), 64'd1);
        exp_q.push_back(model(d, 1'b1));
        recv(0);

`ifndef FEISTEL_LFSR_EN
        // zero keys and zero block stay zero without the LFSR term
        pulse_reload();
        for (int i = 0; i < R; i++) gen_keys[i] = '0;
        cached_keys = gen_keys;
        send(64'h0, 1'b0);
        exp_q.push_back(64'h0);
        recv(0);
`endif

        check("kg_start_outside_fetch", 64'(viol_cnt), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
